project_driver: RTL and testbench

//  Initiator for the 8-bit start/valor/resultado/done compute unit ("project").
//  On go, issues N_OPS operations with operands FIRST_VALUE, +STEP, ...
//  - pulses start, holds valor, waits for done, captures resultado.

---
 rtl/project_driver.sv | 107 ++++++++++
 tb/tb_project_driver.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/project_driver.sv
// Initiator for the start/valor/resultado/done compute unit: runs N_OPS operations
// on an arithmetic operand sequence and accumulates the captured results.
module project_driver #(
  parameter int unsigned N_OPS       = 4,
  parameter logic [7:0]  FIRST_VALUE = 8'd3,
  parameter logic [7:0]  STEP        = 8'd1,
  parameter int unsigned TIMEOUT     = 64
) (
  input  logic        clk0,
  input  logic        rst0,
  input  logic        go,
  input  logic [7:0]  result_in,
  input  logic        done_in,
  output logic        start_out,
  output logic [7:0]  valor_out,
  output logic [7:0]  last_result,
  output logic        result_valid,
  output logic [15:0] sum_out,
  output logic [7:0]  op_count,
  output logic        busy,
  output logic        finished,
  output logic        timeout_err
);

  localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_FINISH
  } state_t;

  state_t        state;
  logic [7:0]    idx;
  logic [TW-1:0] timer;

  // start_out/result_valid/finished are one-cycle pulses; everything else holds.
  always_ff @(posedge clk0) begin
    if (rst0) begin
      state        <= S_IDLE;
      idx          <= 8'd0;
      timer        <= '0;
      start_out    <= 1'b0;
      valor_out    <= 8'd0;
      last_result  <= 8'd0;
      result_valid <= 1'b0;
      sum_out      <= 16'd0;
      op_count     <= 8'd0;
      busy         <= 1'b0;
      finished     <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      start_out    <= 1'b0;
      result_valid <= 1'b0;
      finished     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (go) begin
            valor_out   <= FIRST_VALUE;
            sum_out     <= 16'd0;
            op_count    <= 8'd0;
            timeout_err <= 1'b0;
            idx         <= 8'd0;
            start_out   <= 1'b1;
            busy        <= 1'b1;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          timer <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // A done arriving on the expiry cycle still counts as a capture.
          if (done_in) begin
            last_result  <= result_in;
            result_valid <= 1'b1;
            sum_out      <= sum_out + 16'(result_in);
            op_count     <= op_count + 8'd1;
            if (idx == 8'(N_OPS - 1)) begin
              finished <= 1'b1;
              state    <= S_FINISH;
            end else begin
              idx       <= idx + 8'd1;
              valor_out <= valor_out + STEP;
              start_out <= 1'b1;
              state     <= S_ISSUE;
            end
          end else if (timer == TW'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            finished    <= 1'b1;
            state       <= S_FINISH;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_FINISH: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_project_driver.sv
// Scoreboard bench for project_driver: behavioural compute unit, two driver instances
// (default parameters and a wrapping operand sequence).
module tb_project_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0 = 1'b1;
  logic       go_a = 1'b0;
  logic       go_b = 1'b0;
  logic       sel  = 1'b0;
  logic       done_in = 1'b0;
  logic [7:0] result_in = 8'd0;

  logic start_a, rv_a, busy_a, fin_a, terr_a;
  logic [7:0] valor_a, last_a, opc_a;
  logic [15:0] sum_a;
  logic start_b, rv_b, busy_b, fin_b, terr_b;
  logic [7:0] valor_b, last_b, opc_b;
  logic [15:0] sum_b;

  project_driver u_a (
    .clk0(clk), .rst0(rst0), .go(go_a), .result_in(result_in), .done_in(done_in),
    .start_out(start_a), .valor_out(valor_a), .last_result(last_a), .result_valid(rv_a),
    .sum_out(sum_a), .op_count(opc_a), .busy(busy_a), .finished(fin_a), .timeout_err(terr_a)
  );

  project_driver #(.FIRST_VALUE(8'hFE), .STEP(8'd1)) u_b (
    .clk0(clk), .rst0(rst0), .go(go_b), .result_in(result_in), .done_in(done_in),
    .start_out(start_b), .valor_out(valor_b), .last_result(last_b), .result_valid(rv_b),
    .sum_out(sum_b), .op_count(opc_b), .busy(busy_b), .finished(fin_b), .timeout_err(terr_b)
  );

  // Selected instance as seen by the unit model and the monitor
  logic s_start, s_rv, s_busy, s_fin, s_terr;
  logic [7:0] s_valor, s_last, s_opc;
  logic [15:0] s_sum;
  always_comb begin
    s_start = sel ? start_b : start_a;
    s_rv    = sel ? rv_b    : rv_a;
    s_busy  = sel ? busy_b  : busy_a;
    s_fin   = sel ? fin_b   : fin_a;
    s_terr  = sel ? terr_b  : terr_a;
    s_valor = sel ? valor_b : valor_a;
    s_last  = sel ? last_b  : last_a;
    s_opc   = sel ? opc_b   : opc_a;
    s_sum   = sel ? sum_b   : sum_a;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Compute unit model: done 'lat' cycles after start, held 'hold' cycles, dropped by a new start
  int  lat = 3, hold = 1;
  bit  never = 1'b0, echo = 1'b0;
  int  cnt = 0, hcnt = 0;
  logic [7:0] opnd = 8'd0;
  always @(negedge clk) begin
    if (hcnt > 0) hcnt--;
    if (s_start) begin
      hcnt = 0;
      cnt  = never ? 0 : lat;
      opnd = s_valor;
    end else if (cnt > 0) begin
      cnt--;
      if (cnt == 0) begin
        hcnt      = hold;
        result_in = echo ? opnd : 8'(opnd << 1);
      end
    end
    done_in = (hcnt > 0);
  end

  // Monitor: logs observed operands, captures and timing
  int nstart = 0, nrv = 0, nwait = 0;
  logic [7:0] obs_valor [256];
  logic [7:0] obs_res   [256];
  int         obs_cyc   [256];
  always @(negedge clk) begin
    if (s_start) begin
      obs_valor[nstart % 256] = s_valor;
      obs_cyc[nstart % 256]   = cyc;
      nstart++;
    end
    if (s_rv) begin
      obs_res[nrv % 256] = s_last;
      nrv++;
    end
    if (s_busy && !s_start && !s_fin) nwait++;
  end

  logic [7:0] exp_valor[$];
  logic [7:0] exp_res[$];
  int vectors = 0, miscompares = 0;
  logic [7:0] ev, er;

  task automatic wait_fin(input int maxc, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < maxc && !seen; i++) begin
      @(negedge clk);
      if (s_fin) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst0 = 1'b1;
    repeat (3) @(negedge clk);
    vectors += 2;
    if ({start_a, valor_a, last_a, rv_a, sum_a, opc_a, busy_a, fin_a, terr_a} !== 45'd0) begin
      miscompares++; $display("FAIL reset_a outputs got %h want 0",
        {start_a, valor_a, last_a, rv_a, sum_a, opc_a, busy_a, fin_a, terr_a});
    end
    if ({start_b, valor_b, last_b, rv_b, sum_b, opc_b, busy_b, fin_b, terr_b} !== 45'd0) begin
      miscompares++; $display("FAIL reset_b outputs got %h want 0",
        {start_b, valor_b, last_b, rv_b, sum_b, opc_b, busy_b, fin_b, terr_b});
    end
    rst0 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_defaults();
    int sb, rb; bit seen;
    sel = 1'b0; lat = 3; hold = 1; never = 1'b0; echo = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_valor.push_back(8'(3 + i));
      exp_res.push_back(8'(2 * (3 + i)));
    end
    sb = nstart; rb = nrv;
    go_a = 1'b1; @(negedge clk); go_a = 1'b0;
    vectors++;
    if (s_start !== 1'b1) begin miscompares++; $display("FAIL defaults go_latency start got %b want 1", s_start); end
    wait_fin(100, seen);
    vectors += 5;
    if (!seen) begin miscompares++; $display("FAIL defaults finished timeout got 0 want 1"); end
    if (s_sum !== 16'd36) begin miscompares++; $display("FAIL defaults sum got %0d want 36", s_sum); end
    if (s_opc !== 8'd4) begin miscompares++; $display("FAIL defaults op_count got %0d want 4", s_opc); end
    if (s_terr !== 1'b0) begin miscompares++; $display("FAIL defaults timeout_err got %b want 0", s_terr); end
    if (s_last !== 8'd12) begin miscompares++; $display("FAIL defaults last_result got %0d want 12", s_last); end
    @(negedge clk);
    vectors += 3;
    if ({s_busy, s_fin} !== 2'b00) begin miscompares++; $display("FAIL defaults post_busy_fin got %b want 00", {s_busy, s_fin}); end
    if (nstart - sb !== 4) begin miscompares++; $display("FAIL defaults start_count got %0d want 4", nstart - sb); end
    if (nrv - rb !== 4) begin miscompares++; $display("FAIL defaults capture_count got %0d want 4", nrv - rb); end
    for (int i = 0; i < 4; i++) begin
      ev = exp_valor.pop_front(); er = exp_res.pop_front(); vectors += 2;
      if (obs_valor[(sb + i) % 256] !== ev) begin miscompares++; $display("FAIL defaults valor[%0d] got %h want %h", i, obs_valor[(sb + i) % 256], ev); end
      if (obs_res[(rb + i) % 256] !== er) begin miscompares++; $display("FAIL defaults result[%0d] got %h want %h", i, obs_res[(rb + i) % 256], er); end
    end
  endtask

  task automatic test_timeout();
    int sb, rb, wb; bit seen;
    sel = 1'b0; never = 1'b1;
    sb = nstart; rb = nrv; wb = nwait;
    go_a = 1'b1; @(negedge clk); go_a = 1'b0;
    wait_fin(200, seen);
    vectors += 4;
    if (!seen) begin miscompares++; $display("FAIL timeout finished timeout got 0 want 1"); end
    if (s_terr !== 1'b1) begin miscompares++; $display("FAIL timeout timeout_err got %b want 1", s_terr); end
    if (s_opc !== 8'd0) begin miscompares++; $display("FAIL timeout op_count got %0d want 0", s_opc); end
    if (s_sum !== 16'd0) begin miscompares++; $display("FAIL timeout sum got %0d want 0", s_sum); end
    @(negedge clk);
    vectors += 5;
    if (s_busy !== 1'b0) begin miscompares++; $display("FAIL timeout busy_after got %b want 0", s_busy); end
    if (nstart - sb !== 1) begin miscompares++; $display("FAIL timeout start_count got %0d want 1", nstart - sb); end
    if (nwait - wb !== 64) begin miscompares++; $display("FAIL timeout wait_cycles got %0d want 64", nwait - wb); end
    if (nrv - rb !== 0) begin miscompares++; $display("FAIL timeout capture_count got %0d want 0", nrv - rb); end
    if (obs_valor[sb % 256] !== 8'd3) begin miscompares++; $display("FAIL timeout valor got %h want 03", obs_valor[sb % 256]); end
    never = 1'b0;
  endtask

  task automatic test_wrap();
    int sb, rb; bit seen;
    sel = 1'b1; echo = 1'b1; lat = 3;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      exp_valor.push_back(8'(254 + i));
      exp_res.push_back(8'(254 + i));
    end
    sb = nstart; rb = nrv;
    go_b = 1'b1; @(negedge clk); go_b = 1'b0;
    wait_fin(100, seen);
    vectors += 3;
    if (!seen) begin miscompares++; $display("FAIL wrap finished timeout got 0 want 1"); end
    if (s_sum !== 16'h01FE) begin miscompares++; $display("FAIL wrap sum got %h want 01fe", s_sum); end
    if (s_opc !== 8'd4) begin miscompares++; $display("FAIL wrap op_count got %0d want 4", s_opc); end
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      ev = exp_valor.pop_front(); er = exp_res.pop_front(); vectors += 2;
      if (obs_valor[(sb + i) % 256] !== ev) begin miscompares++; $display("FAIL wrap valor[%0d] got %h want %h", i, obs_valor[(sb + i) % 256], ev); end
      if (obs_res[(rb + i) % 256] !== er) begin miscompares++; $display("FAIL wrap result[%0d] got %h want %h", i, obs_res[(rb + i) % 256], er); end
    end
    echo = 1'b0; sel = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_go_held();
    int sb, rb; bit seen;
    sel = 1'b0; lat = 3; hold = 3;
    for (int i = 0; i < 4; i++) exp_res.push_back(8'(2 * (3 + i)));
    sb = nstart; rb = nrv;
    go_a = 1'b1;
    wait_fin(100, seen);
    go_a = 1'b0;
    vectors += 4;
    if (!seen) begin miscompares++; $display("FAIL go_held finished timeout got 0 want 1"); end
    if (s_opc !== 8'd4) begin miscompares++; $display("FAIL go_held op_count got %0d want 4", s_opc); end
    if (s_sum !== 16'd36) begin miscompares++; $display("FAIL go_held sum got %0d want 36", s_sum); end
    if (s_terr !== 1'b0) begin miscompares++; $display("FAIL go_held timeout_err got %b want 0", s_terr); end
    repeat (4) @(negedge clk);
    vectors += 3;
    if (nstart - sb !== 4) begin miscompares++; $display("FAIL go_held start_count got %0d want 4", nstart - sb); end
    if (nrv - rb !== 4) begin miscompares++; $display("FAIL go_held capture_count got %0d want 4", nrv - rb); end
    if (s_busy !== 1'b0) begin miscompares++; $display("FAIL go_held busy_after got %b want 0", s_busy); end
    for (int i = 0; i < 4; i++) begin
      er = exp_res.pop_front(); vectors++;
      if (obs_res[(rb + i) % 256] !== er) begin miscompares++; $display("FAIL go_held result[%0d] got %h want %h", i, obs_res[(rb + i) % 256], er); end
    end
    hold = 1;
  endtask

  task automatic test_reset_mid();
    int sb, rb, k; bit seen;
    sel = 1'b0; lat = 3; hold = 1; k = 0;
    go_a = 1'b1; @(negedge clk); go_a = 1'b0;
    if (s_start) k++;
    for (int i = 0; i < 50 && k < 2; i++) begin
      @(negedge clk);
      if (s_start) k++;
    end
    vectors++;
    if (k != 2) begin miscompares++; $display("FAIL reset_mid second_start got %0d want 2", k); end
    @(negedge clk);
    rst0 = 1'b1;
    @(negedge clk);
    vectors++;
    if ({start_a, valor_a, last_a, rv_a, sum_a, opc_a, busy_a, fin_a, terr_a} !== 45'd0) begin
      miscompares++; $display("FAIL reset_mid outputs got %h want 0",
        {start_a, valor_a, last_a, rv_a, sum_a, opc_a, busy_a, fin_a, terr_a});
    end
    repeat (3) @(negedge clk);
    rst0 = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      exp_valor.push_back(8'(3 + i));
      exp_res.push_back(8'(2 * (3 + i)));
    end
    sb = nstart; rb = nrv;
    go_a = 1'b1; @(negedge clk); go_a = 1'b0;
    wait_fin(100, seen);
    vectors += 3;
    if (!seen) begin miscompares++; $display("FAIL reset_mid finished timeout got 0 want 1"); end
    if (s_sum !== 16'd36) begin miscompares++; $display("FAIL reset_mid sum got %0d want 36", s_sum); end
    if (s_opc !== 8'd4) begin miscompares++; $display("FAIL reset_mid op_count got %0d want 4", s_opc); end
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      ev = exp_valor.pop_front(); er = exp_res.pop_front(); vectors += 2;
      if (obs_valor[(sb + i) % 256] !== ev) begin miscompares++; $display("FAIL reset_mid valor[%0d] got %h want %h", i, obs_valor[(sb + i) % 256], ev); end
      if (obs_res[(rb + i) % 256] !== er) begin miscompares++; $display("FAIL reset_mid result[%0d] got %h want %h", i, obs_res[(rb + i) % 256], er); end
    end
  endtask

  task automatic test_back_to_back();
    int sb, fc; bit seen;
    sel = 1'b0; lat = 1; hold = 1;
    sb = nstart;
    go_a = 1'b1; @(negedge clk); go_a = 1'b0;
    wait_fin(100, seen);
    fc = cyc;
    vectors += 3;
    if (!seen) begin miscompares++; $display("FAIL b2b finished timeout got 0 want 1"); end
    if (s_opc !== 8'd4) begin miscompares++; $display("FAIL b2b op_count got %0d want 4", s_opc); end
    if (s_sum !== 16'd36) begin miscompares++; $display("FAIL b2b sum got %0d want 36", s_sum); end
    @(negedge clk);
    vectors++;
    if (fc - obs_cyc[sb % 256] !== 8) begin miscompares++; $display("FAIL b2b run_length got %0d want 8", fc - obs_cyc[sb % 256]); end
    for (int i = 1; i < 4; i++) begin
      vectors++;
      if (obs_cyc[(sb + i) % 256] - obs_cyc[(sb + i - 1) % 256] !== 2) begin
        miscompares++; $display("FAIL b2b spacing[%0d] got %0d want 2", i, obs_cyc[(sb + i) % 256] - obs_cyc[(sb + i - 1) % 256]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_timeout();
    test_wrap();
    test_go_held();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
